// File: rtl/serial_add_pkg.sv
// Shared types and defaults for the bit-serial adder controller.
package serial_add_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/serial_add_ctrl_if.sv
// Request/result bundle for serial_add_ctrl; ovf exists only with SERIAL_ADD_OVF_EN.
interface serial_add_ctrl_if
    import serial_add_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             busy;
    logic             done;
`ifdef SERIAL_ADD_OVF_EN
    logic             ovf;

    modport master (output start, a, b, input sum, cout, busy, done, ovf);
    modport slave  (input start, a, b, output sum, cout, busy, done, ovf);
`else
    modport master (output start, a, b, input sum, cout, busy, done);
    modport slave  (input start, a, b, output sum, cout, busy, done);
`endif
endinterface

// File: rtl/serial_add_ctrl_full_add.sv
// One-bit combinational full adder used by the serial datapath.
module full_add (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one result bit per cycle, LSB first, through a single full adder.
// Optional signed-overflow output enabled by defining SERIAL_ADD_OVF_EN.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic              clk,
    input  logic              rst,
    serial_add_ctrl_if.slave  bus
);
    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
`ifdef SERIAL_ADD_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    logic fa_s;
    logic fa_cout;

    full_add u_full_add (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .cin  (carry_q),
        .s    (fa_s),
        .cout (fa_cout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef SERIAL_ADD_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    // Next state and datapath; busy/done are registered from the next state.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
`ifdef SERIAL_ADD_OVF_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    sum_d   = '0;
                    cnt_d   = '0;
                    carry_d = 1'b0;
                    cout_d  = 1'b0;
`ifdef SERIAL_ADD_OVF_EN
                    ovf_d   = 1'b0;
`endif
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                sum_d   = {fa_s, sum_q[WIDTH-1:1]};
                carry_d = fa_cout;
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    cout_d  = fa_cout;
`ifdef SERIAL_ADD_OVF_EN
                    ovf_d   = carry_q ^ fa_cout;
`endif
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);
    end

    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
`ifdef SERIAL_ADD_OVF_EN
    assign bus.ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Randomized and directed bench for serial_add_ctrl against an arithmetic reference model.
module tb_serial_add_ctrl;
    import serial_add_pkg::*;

    localparam int unsigned W = 8;

    logic clk = 1'b0;
    logic rst;

    serial_add_ctrl_if #(.WIDTH(W)) bus ();

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [W:0] model_add(input logic [W-1:0] x, input logic [W-1:0] y);
        return (W+1)'(x) + (W+1)'(y);
    endfunction

    // Signed overflow: operands share a sign that the W-bit result does not.
    function automatic logic model_ovf(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W-1:0] s;
        s = x + y;
        return (x[W-1] == y[W-1]) && (s[W-1] != x[W-1]);
    endfunction

    task automatic check_result(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W:0] r;
        r = model_add(x, y);
        check("sum", 32'(bus.sum), 32'(r[W-1:0]));
        check("cout", 32'(bus.cout), 32'(r[W]));
`ifdef SERIAL_ADD_OVF_EN
        check("ovf", 32'(bus.ovf), 32'(model_ovf(x, y)));
`endif
    endtask

    // Called at the negedge right after the start edge; lat counts edges inclusive of it.
    task automatic wait_done(output int lat, output int busy_cnt);
        lat = 1;
        busy_cnt = 0;
        while (bus.done !== 1'b1 && lat < 40) begin
            busy_cnt += int'(bus.busy);
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic do_add(input logic [W-1:0] x, input logic [W-1:0] y);
        int lat, bc;
        logic [W:0] r;
        r = model_add(x, y);
        @(negedge clk);
        bus.start = 1'b1; bus.a = x; bus.b = y;
        @(negedge clk);
        bus.start = 1'b0; bus.a = W'($urandom); bus.b = W'($urandom);
        wait_done(lat, bc);
        check("latency", 32'(lat), 32'(W + 1));
        check("busy_cycles", 32'(bc), 32'(W));
        check("busy_in_done", 32'(bus.busy), 32'd0);
        check_result(x, y);
        @(negedge clk);
        check("done_one_cycle", 32'(bus.done), 32'd0);
        check("sum_hold", 32'(bus.sum), 32'(r[W-1:0]));
        check("cout_hold", 32'(bus.cout), 32'(r[W]));
    endtask

    initial begin
        int lat, bc, gap, t;
        logic saw_done;
        logic [W-1:0] x, y;

        rst = 1'b1; bus.start = 1'b1; bus.a = '1; bus.b = '1;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_sum", 32'(bus.sum), 32'd0);
        check("rst_cout", 32'(bus.cout), 32'd0);
        rst = 1'b0; bus.start = 1'b0;

        do_add(8'h3C, 8'h05);
        do_add(8'hFF, 8'h01);
        do_add(8'h7F, 8'h01);
        do_add(8'h80, 8'h80);
        do_add(8'h00, 8'h00);
        for (int i = 0; i < 20; i++) do_add(W'($urandom), W'($urandom));

        // Reset four cycles into a run aborts it with no done pulse.
        @(negedge clk);
        bus.start = 1'b1; bus.a = 8'hAA; bus.b = 8'h55;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_rst_busy", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_sum", 32'(bus.sum), 32'd0);
        check("abort_cout", 32'(bus.cout), 32'd0);
        saw_done = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (bus.done === 1'b1 || bus.busy === 1'b1) saw_done = 1'b1;
            @(negedge clk);
        end
        check("abort_no_done", 32'(saw_done), 32'd0);
        do_add(8'h12, 8'h34);

        // Start reasserted during RUN is ignored until the following IDLE.
        @(negedge clk);
        bus.start = 1'b1; bus.a = 8'h10; bus.b = 8'h20;
        @(negedge clk);
        bus.a = 8'h01; bus.b = 8'h01;
        wait_done(lat, bc);
        check("ign_latency", 32'(lat), 32'(W + 1));
        check_result(8'h10, 8'h20);
        @(negedge clk);
        check("ign_idle_busy", 32'(bus.busy), 32'd0);
        check("ign_idle_sum", 32'(bus.sum), 32'h30);
        @(negedge clk);
        check("ign_restart_busy", 32'(bus.busy), 32'd1);
        bus.start = 1'b0;
        wait_done(lat, bc);
        check("ign2_latency", 32'(lat), 32'(W + 1));
        check_result(8'h01, 8'h01);
        @(negedge clk);

        // Back-to-back with start held high; operands change right after each done.
        x = W'($urandom); y = W'($urandom);
        bus.start = 1'b1; bus.a = x; bus.b = y;
        t = 0;
        for (int k = 0; k < 5; k++) begin
            gap = 0;
            do begin
                @(negedge clk);
                t++; gap++;
            end while (bus.done !== 1'b1 && gap < 40);
            if (k > 0) check("b2b_period", 32'(gap), 32'(W + 2));
            check_result(x, y);
            x = W'($urandom); y = W'($urandom);
            bus.a = x; bus.b = y;
        end
        bus.start = 1'b0;
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width in bits (legal range 2..32).
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request to add a and b; sampled only in IDLE.
REQ-005 SHALL have port a  input  WIDTH  operand A, captured on the accepted start.
REQ-006 SHALL have port b  input  WIDTH  operand B, captured on the accepted start.
REQ-007 SHALL have port sum  output  WIDTH  result register, LSB-first serial build.
REQ-008 SHALL have port cout  output  1  final carry out of the MSB.
REQ-009 SHALL have port busy  output  1  high while in RUN.
REQ-010 SHALL have port done  output  1  one-cycle pulse when sum/cout are final.
REQ-011 SHALL have port ovf  output  1  signed overflow, present only with SERIAL_ADD_OVF_EN.

Function
REQ-012 SHALL implement FSM states IDLE, RUN and DONE.
REQ-013 IDLE with start=1 at an edge SHALL capture a and b into shift registers, clear the carry register, clear sum, set the bit counter to 0 and go to RUN.
REQ-014 IDLE with start=0 SHALL hold all registers.
REQ-015 Each RUN edge SHALL feed operand LSBs and the carry register to one 1-bit full adder, shift its sum bit into the MSB of sum, store its carry, shift both operands right and increment the counter.
REQ-016 The RUN edge with counter = WIDTH-1 SHALL go to DONE, leaving sum final and cout equal to the last carry.
REQ-017 Latency: done SHALL be high exactly in the cycle following the WIDTH-th edge after the start-sampling edge, i.e. WIDTH+1 edges inclusive.
REQ-018 DONE SHALL go to IDLE on the next edge unconditionally; done is high only in DONE.
REQ-019 sum and cout SHALL hold their final values from DONE until the next accepted start.
REQ-020 start SHALL be ignored in RUN and DONE; a start held high through DONE is accepted in the following IDLE cycle.
REQ-021 busy SHALL be high exactly in RUN.
REQ-022 Arithmetic SHALL be unsigned modulo 2^WIDTH with the carry reported on cout.
REQ-023 Inputs a and b SHALL be don't-care outside the start-sampling edge.

Reset
REQ-024 rst=1 at an edge SHALL force IDLE and clear sum, cout, carry, counter, operand registers and ovf, overriding start.
REQ-025 After reset, busy=0, done=0, sum=0 and cout=0.
REQ-026 Reset asserted mid-RUN SHALL abort the addition with no done pulse.

Configuration
REQ-027 With macro SERIAL_ADD_OVF_EN defined, port ovf SHALL exist and be registered at the transition to DONE as (carry into MSB) XOR (carry out of MSB), held like sum.
REQ-028 Without SERIAL_ADD_OVF_EN, port ovf and its logic SHALL be absent; all other behaviour SHALL be unchanged.

Structure
REQ-029 State encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the default WIDTH SHALL reside in the shared package serial_add_pkg.
REQ-030 The per-bit adder SHALL be a separate combinational sub-module full_add (a, b, cin -> s, cout), instantiated once.

Verification
REQ-031 WIDTH=8, start with a=8'h3C, b=8'h05 -> done after 9 edges inclusive, sum=8'h41, cout=0, busy high for 8 cycles.
REQ-032 a=8'hFF, b=8'h01 -> sum=8'h00, cout=1; with SERIAL_ADD_OVF_EN, ovf=0.
REQ-033 With SERIAL_ADD_OVF_EN, a=8'h7F, b=8'h01 -> sum=8'h80, cout=0, ovf=1.
REQ-034 rst pulsed 4 cycles into RUN -> next cycle IDLE, busy=0, sum=0, no done pulse; a fresh start then completes normally.
REQ-035 start re-asserted with a=8'h01, b=8'h01 during RUN of 8'h10+8'h20 -> first result 8'h30 unaffected; second start accepted only in IDLE, yielding 8'h02.
REQ-036 Back-to-back: start held high continuously -> done pulses every WIDTH+2 cycles with results correct each time.
